// File: rtl/reset_sequencer_pkg.sv
// reset_sequencer_pkg: shared state type, limits and counter sizing for the reset sequencer
package reset_sequencer_pkg;
  typedef enum logic [1:0] {WAIT_LOCK, HOLD, RELEASE, RUN} seq_state_t;
  localparam logic [7:0] LOSS_SAT = 8'hFF;
  function automatic int cnt_width(input int lock_filter, input int hold_cycles, input int n_domains, input int stage_gap);
    int m;
    m = lock_filter > hold_cycles ? lock_filter : hold_cycles;
    m = m > (n_domains - 1) * stage_gap ? m : (n_domains - 1) * stage_gap;
    return $clog2(m + 1) < 1 ? 1 : $clog2(m + 1);
  endfunction
endpackage

// File: rtl/reset_sequencer_if.sv
// reset_sequencer_if: software handshake and reset-tree outputs of the reset sequencer
interface reset_sequencer_if #(parameter int N_DOMAINS = 3);
  logic sw_rst_req;
  logic sw_rst_ack;
  logic [N_DOMAINS-1:0] domain_rst;
  logic sys_ready;
  logic [7:0] lock_loss_cnt;
  modport master(input sw_rst_req, output sw_rst_ack, domain_rst, sys_ready, lock_loss_cnt);
  modport slave(output sw_rst_req, input sw_rst_ack, domain_rst, sys_ready, lock_loss_cnt);
endinterface

// File: rtl/reset_sequencer_reset_sync.sv
// reset_sync: asynchronous-assert, synchronous-deassert active-low reset synchronizer
module reset_sync #(parameter int SYNC_STAGES = 2) (
  input  logic clk,
  input  logic rst_n,
  output logic rst_sync_n
);
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], 1'b1};
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sync_q <= '0;
    else sync_q <= sync_d;
  assign rst_sync_n = sync_q[SYNC_STAGES-1];
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: lock-filtered, hold-timed, staged release of the domain reset tree
module reset_sequencer
  import reset_sequencer_pkg::*;
#(
  parameter int N_DOMAINS   = 3,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_FILTER = 8,
  parameter int HOLD_CYCLES = 16,
  parameter int STAGE_GAP   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_locked,
  reset_sequencer_if.master bus
);
  localparam int CW = cnt_width(LOCK_FILTER, HOLD_CYCLES, N_DOMAINS, STAGE_GAP);
  localparam logic [CW-1:0] LF_C = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] HC_C = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] SG_C = CW'(STAGE_GAP - 1);
  logic rst_sync_n, lock_s;
  logic [SYNC_STAGES-1:0] lock_sync_q, lock_sync_d;
  seq_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N_DOMAINS-1:0] domain_rst_q, domain_rst_d;
  logic sys_ready_q, sys_ready_d;
  logic sw_rst_ack_q, sw_rst_ack_d;
  logic [7:0] lock_loss_cnt_q, lock_loss_cnt_d;
  reset_sync #(.SYNC_STAGES(SYNC_STAGES)) u_reset_sync (
    .clk(clk),
    .rst_n(rst_n),
    .rst_sync_n(rst_sync_n)
  );
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  always_comb begin
    lock_sync_d = {lock_sync_q[SYNC_STAGES-2:0], pll_locked};
    state_d = state_q;
    cnt_d = cnt_q;
    domain_rst_d = domain_rst_q;
    sys_ready_d = sys_ready_q;
    sw_rst_ack_d = 1'b0;
    lock_loss_cnt_d = lock_loss_cnt_q;
    if (state_q != WAIT_LOCK && !lock_s) begin
      state_d = WAIT_LOCK;
      cnt_d = '0;
      domain_rst_d = '1;
      sys_ready_d = 1'b0;
      lock_loss_cnt_d = lock_loss_cnt_q == LOSS_SAT ? lock_loss_cnt_q : lock_loss_cnt_q + 8'd1;
    end else if (state_q == WAIT_LOCK) begin
      cnt_d = !lock_s || cnt_q == LF_C ? '0 : cnt_q + 1'b1;
      state_d = lock_s && cnt_q == LF_C ? HOLD : WAIT_LOCK;
    end else if (state_q == RUN) begin
      if (bus.sw_rst_req) begin
        state_d = HOLD;
        cnt_d = '0;
        domain_rst_d = '1;
        sys_ready_d = 1'b0;
        sw_rst_ack_d = 1'b1;
      end
    end else if (cnt_q == (state_q == HOLD ? HC_C : SG_C)) begin
      cnt_d = '0;
      domain_rst_d = domain_rst_q << 1;
      sys_ready_d = ~|domain_rst_d;
      state_d = sys_ready_d ? RUN : RELEASE;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_sync_n)
    if (!rst_sync_n) begin
      lock_sync_q <= '0;
      state_q <= WAIT_LOCK;
      cnt_q <= '0;
      domain_rst_q <= '1;
      sys_ready_q <= 1'b0;
      sw_rst_ack_q <= 1'b0;
      lock_loss_cnt_q <= '0;
    end else begin
      lock_sync_q <= lock_sync_d;
      state_q <= state_d;
      cnt_q <= cnt_d;
      domain_rst_q <= domain_rst_d;
      sys_ready_q <= sys_ready_d;
      sw_rst_ack_q <= sw_rst_ack_d;
      lock_loss_cnt_q <= lock_loss_cnt_d;
    end
  assign bus.domain_rst = domain_rst_q;
  assign bus.sys_ready = sys_ready_q;
  assign bus.sw_rst_ack = sw_rst_ack_q;
  assign bus.lock_loss_cnt = lock_loss_cnt_q;
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed and randomized steps checked against a timeline-level reference model
module tb_reset_sequencer;
  localparam int N = 3, SS = 2, LF = 8, HC = 16, SG = 4;
  logic clk = 1'b0, rst_n = 1'b1, pll_locked = 1'b0;
  int checks = 0, errors = 0;
  int rst_hi, filt, seq, loss, lb;
  bit waiting, ack;
  bit lq[$];
  reset_sequencer_if #(.N_DOMAINS(N)) bus();
  reset_sequencer #(.N_DOMAINS(N), .SYNC_STAGES(SS), .LOCK_FILTER(LF), .HOLD_CYCLES(HC), .STAGE_GAP(SG)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .pll_locked(pll_locked),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task m_reset();
    rst_hi = 0;
    waiting = 1;
    filt = 0;
    seq = 0;
    loss = 0;
    ack = 0;
    lq.delete();
    repeat (SS) lq.push_back(1'b0);
  endtask
  task m_edge();
    bit ls, ra;
    ls = lq[0];
    ra = rst_hi < SS;
    ack = 0;
    if (ra) begin
      waiting = 1;
      filt = 0;
      seq = 0;
      loss = 0;
    end else if (waiting) begin
      if (!ls) filt = 0;
      else if (filt == LF) begin
        waiting = 0;
        seq = 0;
      end else filt++;
    end else if (!ls) begin
      loss = loss < 255 ? loss + 1 : 255;
      waiting = 1;
      filt = 0;
    end else if (seq >= HC + (N - 1) * SG && bus.sw_rst_req) begin
      seq = 0;
      ack = 1;
    end else if (seq < 100000) seq++;
    void'(lq.pop_front());
    lq.push_back(ra ? 1'b0 : pll_locked);
    if (rst_n) rst_hi++;
  endtask
  task check();
    logic [N-1:0] ed;
    for (int i = 0; i < N; i++) ed[i] = waiting || seq < HC + i * SG;
    cmp("domain_rst", bus.domain_rst, ed);
    cmp("sys_ready", bus.sys_ready, !waiting && seq >= HC + (N - 1) * SG);
    cmp("sw_rst_ack", bus.sw_rst_ack, ack);
    cmp("lock_loss_cnt", bus.lock_loss_cnt, loss);
  endtask
  task tick();
    @(posedge clk);
    m_edge();
    #1;
    check();
  endtask
  task async_reset();
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check();
  endtask
  task settle(input int n);
    pll_locked = 1'b1;
    bus.sw_rst_req = 1'b0;
    repeat (n) tick();
  endtask
  initial begin
    bus.sw_rst_req = 1'b0;
    pll_locked = 1'b1;
    #1;
    rst_n = 1'b0;
    m_reset();
    repeat (5) tick();
    rst_n = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      tick();
      cmp("pwrup_dom", bus.domain_rst, k < 29 ? 7 : k < 33 ? 6 : k < 37 ? 4 : 0);
      cmp("pwrup_ready", bus.sys_ready, k >= 37);
    end
    cmp("pwrup_loss", bus.lock_loss_cnt, 0);
    bus.sw_rst_req = 1'b1;
    tick();
    cmp("sw_ack", bus.sw_rst_ack, 1);
    cmp("sw_dom", bus.domain_rst, 7);
    for (int k = 1; k <= 26; k++) begin
      bus.sw_rst_req = (k == 3);
      tick();
      cmp("sw_seq_dom", bus.domain_rst, k < 16 ? 7 : k < 20 ? 6 : k < 24 ? 4 : 0);
      cmp("sw_seq_ready", bus.sys_ready, k >= 24);
      cmp("sw_seq_noack", bus.sw_rst_ack, 0);
    end
    bus.sw_rst_req = 1'b1;
    repeat (70) tick();
    settle(40);
    pll_locked = 1'b0;
    tick();
    cmp("loss_run_e1", bus.sys_ready, 1);
    tick();
    cmp("loss_run_e2", bus.sys_ready, 1);
    tick();
    cmp("loss_run_dom", bus.domain_rst, 7);
    cmp("loss_run_ready", bus.sys_ready, 0);
    cmp("loss_run_cnt", bus.lock_loss_cnt, 1);
    pll_locked = 1'b1;
    repeat ($urandom_range(3, 6)) tick();
    pll_locked = 1'b0;
    tick();
    pll_locked = 1'b1;
    repeat (45) tick();
    cmp("glitch_cnt", bus.lock_loss_cnt, 1);
    settle(10);
    lb = loss;
    pll_locked = 1'b0;
    repeat (2) tick();
    bus.sw_rst_req = 1'b1;
    tick();
    cmp("simul_noack", bus.sw_rst_ack, 0);
    cmp("simul_cnt", bus.lock_loss_cnt, lb + 1);
    cmp("simul_dom", bus.domain_rst, 7);
    bus.sw_rst_req = 1'b0;
    pll_locked = 1'b1;
    tick();
    cmp("simul_noack2", bus.sw_rst_ack, 0);
    settle(45);
    for (int k = 0; k < 400; k++) begin
      pll_locked = $urandom_range(0, 59) != 0;
      bus.sw_rst_req = $urandom_range(0, 7) == 0;
      tick();
    end
    settle(10);
    async_reset();
    repeat (5) tick();
    rst_n = 1'b1;
    repeat (30) tick();
    cmp("pre_async_dom", bus.domain_rst, 6);
    async_reset();
    cmp("async_dom", bus.domain_rst, 7);
    cmp("async_cnt", bus.lock_loss_cnt, 0);
    repeat (3) tick();
    rst_n = 1'b1;
    for (int k = 0; k < 300; k++) begin
      pll_locked = 1'b1;
      repeat (14) tick();
      pll_locked = 1'b0;
      repeat (2) tick();
    end
    cmp("loss_sat", bus.lock_loss_cnt, 255);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
